// File: rtl/hex_scan_ctrl.sv
// Eight-digit multiplexed hex display scanner with tear-free frame reload
// and optional leading-zero blanking.
module hex_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] display_in,
    input  logic        display_we,
    input  logic        blank_lz,
    output logic [6:0]  seg_n,
    output logic [7:0]  dig_en_n,
    output logic        frame_done,
    output logic [31:0] shown
);

    localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] TC = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   pend_q, pend_d;
    logic [31:0]   act_q, act_d;
    logic          fd_q, fd_d;
    logic [6:0]    seg_q, seg_d;
    logic [7:0]    dig_q, dig_d;

    logic          tc;
    logic          boundary;
    logic [4:0]    sh;
    logic [3:0]    nib;
    logic          lz;

    assign tc       = (presc_q == TC);
    assign boundary = tc && (idx_q == 3'd7);

    // Outputs are decoded from next-state values so the registered
    // segment/digit drive lines up with the index and active word.
    always_comb begin
        presc_d = tc ? '0 : presc_q + 1'b1;
        idx_d   = tc ? idx_q + 3'd1 : idx_q;
        pend_d  = display_we ? display_in : pend_q;
        act_d   = act_q;
        if (boundary) begin
            act_d = display_we ? display_in : pend_q;
        end
        fd_d  = boundary;
        sh    = {idx_d, 2'b00};
        nib   = act_d[sh +: 4];
        lz    = blank_lz && (idx_d != 3'd0) && ((act_d >> sh) == 32'd0);
        dig_d = ~(8'b1 << idx_d);
        seg_d = 7'h7f;
        if (!lz) begin
            unique case (nib)
                4'h0: seg_d = 7'b1000000;
                4'h1: seg_d = 7'b1111001;
                4'h2: seg_d = 7'b0100100;
                4'h3: seg_d = 7'b0110000;
                4'h4: seg_d = 7'b0011001;
                4'h5: seg_d = 7'b0010010;
                4'h6: seg_d = 7'b0000010;
                4'h7: seg_d = 7'b1111000;
                4'h8: seg_d = 7'b0000000;
                4'h9: seg_d = 7'b0010000;
                4'ha: seg_d = 7'b0001000;
                4'hb: seg_d = 7'b0000011;
                4'hc: seg_d = 7'b1000110;
                4'hd: seg_d = 7'b0100001;
                4'he: seg_d = 7'b0000110;
                4'hf: seg_d = 7'b0001110;
                default: seg_d = 7'h7f;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            pend_q  <= '0;
            act_q   <= '0;
            fd_q    <= 1'b0;
            seg_q   <= 7'b1000000;
            dig_q   <= 8'b11111110;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            fd_q    <= fd_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
        end
    end

    assign seg_n      = seg_q;
    assign dig_en_n   = dig_q;
    assign frame_done = fd_q;
    assign shown      = act_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Scoreboard bench for hex_scan_ctrl with SCAN_DIV=4 (32-cycle frames).
module tb_hex_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] display_in = '0;
    logic        display_we = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg_n;
    logic [7:0]  dig_en_n;
    logic        frame_done;
    logic [31:0] shown;

    hex_scan_ctrl #(.SCAN_DIV(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .display_in(display_in),
        .display_we(display_we),
        .blank_lz(blank_lz),
        .seg_n(seg_n),
        .dig_en_n(dig_en_n),
        .frame_done(frame_done),
        .shown(shown)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  seg;
        logic [7:0]  dig;
        logic        fd;
        logic [31:0] shown;
    } exp_t;

    exp_t sbq[$];
    int n_chk = 0;
    int n_err = 0;

    // reference model state: edge count within frame, pending, active
    int          m_cnt;
    logic [31:0] m_pend;
    logic [31:0] m_act;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] exp_seg(input logic [31:0] a,
                                           input int idx,
                                           input logic blz);
        logic allz;
        logic [3:0] nb;
        allz = 1'b1;
        for (int j = idx; j < 8; j++) begin
            nb = a[j*4 +: 4];
            if (nb != 4'h0) allz = 1'b0;
        end
        nb = a[idx*4 +: 4];
        if (blz && idx > 0 && allz) return 7'h7f;
        return SEG_TAB[nb];
    endfunction

    // Drive one cycle, advance the model, push the expected outputs.
    task automatic cyc(input logic we, input logic [31:0] din);
        exp_t e;
        logic bnd;
        display_we = we;
        display_in = din;
        bnd = (m_cnt == 31);
        if (bnd) m_act = we ? din : m_pend;
        if (we) m_pend = din;
        m_cnt = (m_cnt + 1) % 32;
        e.seg = exp_seg(m_act, m_cnt / 4, blank_lz);
        e.dig = ~(8'b1 << (m_cnt / 4));
        e.fd = bnd;
        e.shown = m_act;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        display_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        display_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_cnt = 0;
        m_pend = '0;
        m_act = '0;
        sbq.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (seg_n !== 7'b1000000) begin
            n_err++;
            $display("FAIL reset_seg got=%b exp=1000000", seg_n);
        end
        n_chk++;
        if (dig_en_n !== 8'b11111110) begin
            n_err++;
            $display("FAIL reset_dig got=%b exp=11111110", dig_en_n);
        end
        n_chk++;
        if (frame_done !== 1'b0 || shown !== 32'h0) begin
            n_err++;
            $display("FAIL reset_fd_shown got=%b/%h exp=0/0",
                     frame_done, shown);
        end
    endtask

    task automatic test_idle();
        exp_t e;
        int first_fd;
        first_fd = -1;
        blank_lz = 1'b0;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            cyc(1'b0, 32'h0);
            e = sbq.pop_front();
            if (frame_done === 1'b1 && first_fd < 0) first_fd = k;
            n_chk++;
            if ({seg_n, dig_en_n, frame_done, shown} !== e) begin
                n_err++;
                $display("FAIL idle k=%0d got=%b/%b/%b/%h exp=%b/%b/%b/%h",
                         k, seg_n, dig_en_n, frame_done, shown,
                         e.seg, e.dig, e.fd, e.shown);
            end
        end
        n_chk++;
        if (first_fd != 32) begin
            n_err++;
            $display("FAIL idle_fd_cycle got=%0d exp=32", first_fd);
        end
    endtask

    task automatic run_load(input string nm, input logic [31:0] val,
                            input logic blz, input int at,
                            output logic [6:0] d0, output logic [6:0] d7);
        exp_t e;
        blank_lz = blz;
        d0 = 'x;
        d7 = 'x;
        do_reset();
        for (int k = 1; k <= 72; k++) begin
            cyc(k == at, val);
            e = sbq.pop_front();
            if (shown === val && dig_en_n === 8'hfe) d0 = seg_n;
            if (shown === val && dig_en_n === 8'h7f) d7 = seg_n;
            n_chk++;
            if ({seg_n, dig_en_n, frame_done, shown} !== e) begin
                n_err++;
                $display("FAIL %s k=%0d got=%b/%b/%b/%h exp=%b/%b/%b/%h",
                         nm, k, seg_n, dig_en_n, frame_done, shown,
                         e.seg, e.dig, e.fd, e.shown);
            end
        end
    endtask

    task automatic test_load_hex();
        logic [6:0] d0, d7;
        run_load("load_hex", 32'h89abcdef, 1'b0, 5, d0, d7);
        n_chk++;
        if (d0 !== 7'b0001110 || d7 !== 7'b0000000) begin
            n_err++;
            $display("FAIL load_hex_digits got=%b/%b exp=0001110/0000000",
                     d0, d7);
        end
    endtask

    task automatic test_blank();
        logic [6:0] d0, d7;
        run_load("blank_a05", 32'h00000a05, 1'b1, 1, d0, d7);
        n_chk++;
        if (d0 !== 7'b0010010 || d7 !== 7'h7f) begin
            n_err++;
            $display("FAIL blank_a05_digits got=%b/%b exp=0010010/1111111",
                     d0, d7);
        end
        run_load("blank_zero", 32'h0, 1'b1, 1, d0, d7);
        n_chk++;
        if (d0 !== 7'b1000000 || d7 !== 7'h7f) begin
            n_err++;
            $display("FAIL blank_zero_digits got=%b/%b exp=1000000/1111111",
                     d0, d7);
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int seen11;
        seen11 = 0;
        blank_lz = 1'b0;
        do_reset();
        for (int k = 1; k <= 72; k++) begin
            if (m_cnt == 10 && k < 32) cyc(1'b1, 32'h11111111);
            else if (m_cnt == 31 && k < 40) cyc(1'b1, 32'h22222222);
            else cyc(1'b0, 32'h0);
            e = sbq.pop_front();
            if (shown === 32'h11111111) seen11++;
            n_chk++;
            if ({seg_n, dig_en_n, frame_done, shown} !== e) begin
                n_err++;
                $display("FAIL b2b k=%0d got=%b/%b/%b/%h exp=%b/%b/%b/%h",
                         k, seg_n, dig_en_n, frame_done, shown,
                         e.seg, e.dig, e.fd, e.shown);
            end
        end
        n_chk++;
        if (seen11 != 0 || shown !== 32'h22222222) begin
            n_err++;
            $display("FAIL b2b_tear got=%0d/%h exp=0/22222222",
                     seen11, shown);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        blank_lz = 1'b0;
        do_reset();
        for (int k = 1; k <= 45; k++) cyc(k == 3, 32'h12345678);
        cyc(1'b1, 32'hcafef00d);
        sbq.delete();
        #2;
        rst_n = 1'b0;
        display_we = 1'b1;
        display_in = 32'hdeadbeef;
        #1;
        n_chk++;
        if ({seg_n, dig_en_n, frame_done, shown} !==
            {7'b1000000, 8'b11111110, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL async_rst got=%b/%b/%b/%h exp=1000000/11111110/0/0",
                     seg_n, dig_en_n, frame_done, shown);
        end
        repeat (2) @(posedge clk);
        #1;
        display_we = 1'b0;
        rst_n = 1'b1;
        m_cnt = 0;
        m_pend = '0;
        m_act = '0;
        for (int k = 1; k <= 36; k++) begin
            cyc(1'b0, 32'h0);
            e = sbq.pop_front();
            n_chk++;
            if ({seg_n, dig_en_n, frame_done, shown} !== e) begin
                n_err++;
                $display("FAIL post_rst k=%0d got=%b/%b/%b/%h exp=%b/%b/%b/%h",
                         k, seg_n, dig_en_n, frame_done, shown,
                         e.seg, e.dig, e.fd, e.shown);
            end
        end
        n_chk++;
        if (shown !== 32'h0) begin
            n_err++;
            $display("FAIL pend_cleared got=%h exp=00000000", shown);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_load_hex();
        test_blank();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
